// File: rtl/pytxscobufctrl_pkg.sv
// Shared types and constants for the SCO/eSCO transmit payload double buffer.
package pytxscobufctrl_pkg;

  localparam int          SCO_BANK_AW = 7;
  localparam logic [31:0] SCO_SILENCE = 32'h0;

  typedef enum logic [1:0] {
    BK_EMPTY    = 2'd0,
    BK_FILLING  = 2'd1,
    BK_FULL     = 2'd2,
    BK_DRAINING = 2'd3
  } bank_st_e;

  typedef struct packed {
    logic                   en;
    logic                   we;
    logic [SCO_BANK_AW:0]   addr;
    logic [31:0]            din;
  } sram_req_t;

endpackage

// File: rtl/pytxscobufctrl_sram256x32_1p.sv
// Single-port synchronous SRAM: one access per cycle, read data one cycle later.
module sram256x32_1p #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    q         <= mem[addr];
    end
  end

endmodule

// File: rtl/pytxscobufctrl.sv
// SCO/eSCO TX payload double buffer: link controller fills one bank while the
// BSM drains the other; banks swap on the Tsco anchor pulse.
module pytxscobufctrl
  import pytxscobufctrl_pkg::*;
#(
  parameter int          BANK_AW = SCO_BANK_AW,
  parameter logic [31:0] SILENCE = SCO_SILENCE
) (
  input  logic               clk_6M,
  input  logic               rstz,
  input  logic               sco_en,
  input  logic               tsco_p,
  input  logic [BANK_AW-1:0] pyl_words,
  input  logic [BANK_AW-1:0] lnctrl_addr,
  input  logic [31:0]        lnctrl_din,
  input  logic               lnctrl_we,
  input  logic               lnctrl_commit,
  output logic               lnctrl_rdy,
  input  logic               bsm_rd_start,
  input  logic               bsm_rd,
  output logic [31:0]        bsm_dout,
  output logic               bsm_dvalid,
  output logic               bsm_silence,
  output logic               underrun_p,
  output logic               overflow_p
);

  logic               fill_sel;
  bank_st_e           bank_st [2];
  logic [1:0]         bank_dirty;
  logic               drain_ok, drain_blank;
  logic [BANK_AW-1:0] rd_ptr, rd_last, rd_ptr_eff;
  logic               rd_sil_q;
  logic [31:0]        sram_q;
  sram_req_t          req;

  bank_st_e fill_st, drain_st, fill_cmt;
  logic     writable, rd_acc, wr_acc, rd_ok;

  assign fill_st    = bank_st[fill_sel];
  assign drain_st   = bank_st[~fill_sel];
  assign writable   = (fill_st == BK_EMPTY) || (fill_st == BK_FILLING);
  // BSM read owns the single SRAM port; a held write simply waits it out.
  assign rd_acc     = sco_en & bsm_rd;
  assign lnctrl_rdy = sco_en & lnctrl_we & ~rd_acc;
  assign wr_acc     = lnctrl_rdy & writable;
  assign rd_ptr_eff = bsm_rd_start ? '0 : rd_ptr;

  assign bsm_silence = (drain_st == BK_DRAINING) & ~drain_ok;
  // A bank committed without any write carries an all-silence payload.
  assign rd_ok       = (drain_st == BK_DRAINING) & drain_ok & ~drain_blank;
  assign bsm_dout    = (bsm_dvalid && !rd_sil_q) ? sram_q : SILENCE;

  // Fill-bank state after this cycle's write/commit, before any swap.
  always_comb begin
    fill_cmt = fill_st;
    if (wr_acc && fill_st == BK_EMPTY) fill_cmt = BK_FILLING;
    if (lnctrl_commit && writable)     fill_cmt = BK_FULL;
  end

  always_comb begin
    req      = '0;
    req.en   = rd_acc | wr_acc;
    req.we   = wr_acc;
    req.addr = rd_acc ? {~fill_sel, rd_ptr_eff} : {fill_sel, lnctrl_addr};
    req.din  = lnctrl_din;
  end

  sram256x32_1p #(.AW(BANK_AW + 1), .DW(32)) u_sram (
    .clk  (clk_6M),
    .en   (req.en),
    .we   (req.we),
    .addr (req.addr),
    .din  (req.din),
    .q    (sram_q)
  );

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      fill_sel    <= 1'b0;
      bank_st[0]  <= BK_EMPTY;
      bank_st[1]  <= BK_EMPTY;
      bank_dirty  <= '0;
      drain_ok    <= 1'b0;
      drain_blank <= 1'b0;
      rd_ptr      <= '0;
      rd_last     <= '0;
      rd_sil_q    <= 1'b0;
      bsm_dvalid  <= 1'b0;
      underrun_p  <= 1'b0;
      overflow_p  <= 1'b0;
    end else if (!sco_en) begin
      fill_sel    <= 1'b0;
      bank_st[0]  <= BK_EMPTY;
      bank_st[1]  <= BK_EMPTY;
      bank_dirty  <= '0;
      drain_ok    <= 1'b0;
      drain_blank <= 1'b0;
      rd_ptr      <= '0;
      rd_last     <= '0;
      rd_sil_q    <= 1'b0;
      bsm_dvalid  <= 1'b0;
      underrun_p  <= 1'b0;
      overflow_p  <= 1'b0;
    end else begin
      bsm_dvalid <= rd_acc;
      rd_sil_q   <= ~rd_ok;
      overflow_p <= lnctrl_rdy & ~writable;
      underrun_p <= 1'b0;
      if (wr_acc) bank_dirty[fill_sel] <= 1'b1;
      if (tsco_p) begin
        // Commit is folded into fill_cmt first, so a coincident commit is not an underrun.
        bank_st[fill_sel]     <= BK_DRAINING;
        bank_st[~fill_sel]    <= BK_EMPTY;
        bank_dirty[~fill_sel] <= 1'b0;
        drain_ok              <= (fill_cmt == BK_FULL);
        drain_blank           <= ~(bank_dirty[fill_sel] | wr_acc);
        underrun_p            <= (fill_cmt != BK_FULL);
        fill_sel              <= ~fill_sel;
        rd_ptr                <= '0;
        rd_last               <= pyl_words - 1'b1;
      end else begin
        bank_st[fill_sel] <= fill_cmt;
        if (rd_acc)
          rd_ptr <= (rd_ptr_eff == rd_last) ? rd_ptr_eff : rd_ptr_eff + 1'b1;
        else if (bsm_rd_start)
          rd_ptr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pytxscobufctrl.sv
// Directed bench for the SCO TX payload double buffer.
module tb_pytxscobufctrl;
  logic        clk_6M = 1'b0;
  logic        rstz, sco_en, tsco_p, lnctrl_we, lnctrl_commit, lnctrl_rdy;
  logic [6:0]  pyl_words, lnctrl_addr;
  logic [31:0] lnctrl_din, bsm_dout;
  logic        bsm_rd_start, bsm_rd, bsm_dvalid, bsm_silence, underrun_p, overflow_p;
  int          total = 0, bad = 0;

  pytxscobufctrl dut (
    .clk_6M(clk_6M), .rstz(rstz), .sco_en(sco_en), .tsco_p(tsco_p),
    .pyl_words(pyl_words), .lnctrl_addr(lnctrl_addr), .lnctrl_din(lnctrl_din),
    .lnctrl_we(lnctrl_we), .lnctrl_commit(lnctrl_commit), .lnctrl_rdy(lnctrl_rdy),
    .bsm_rd_start(bsm_rd_start), .bsm_rd(bsm_rd), .bsm_dout(bsm_dout),
    .bsm_dvalid(bsm_dvalid), .bsm_silence(bsm_silence),
    .underrun_p(underrun_p), .overflow_p(overflow_p)
  );

  always #5 clk_6M = ~clk_6M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dout"}, bsm_dout, 32'h0);
    chk({tag, "_dvalid"}, {31'h0, bsm_dvalid}, 32'h0);
    chk({tag, "_sil"}, {31'h0, bsm_silence}, 32'h0);
    chk({tag, "_under"}, {31'h0, underrun_p}, 32'h0);
    chk({tag, "_over"}, {31'h0, overflow_p}, 32'h0);
    chk({tag, "_rdy"}, {31'h0, lnctrl_rdy}, 32'h0);
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    lnctrl_we = 1'b1; lnctrl_addr = a; lnctrl_din = d;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1 ok = lnctrl_rdy;
      tick();
    end
    lnctrl_we = 1'b0;
    if (!ok) chk("wr_timeout", {31'h0, ok}, 32'h1);
  endtask

  task automatic commit();
    lnctrl_commit = 1'b1; tick(); lnctrl_commit = 1'b0;
  endtask

  task automatic swap(input logic [6:0] n);
    tsco_p = 1'b1; pyl_words = n; tick(); tsco_p = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] exp);
    bsm_rd = 1'b1; tick(); bsm_rd = 1'b0;
    chk({tag, "_dv"}, {31'h0, bsm_dvalid}, 32'h1);
    chk(tag, bsm_dout, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstz = 1'b0; sco_en = 1'b0; tsco_p = 1'b0; pyl_words = '0;
    lnctrl_addr = '0; lnctrl_din = '0; lnctrl_we = 1'b0; lnctrl_commit = 1'b0;
    bsm_rd_start = 1'b0; bsm_rd = 1'b0;
    tick(); tick();
    chk_idle("reset");
    rstz = 1'b1; sco_en = 1'b1;
    tick();

    // Basic fill / drain of bank 0
    for (int i = 0; i < 10; i++) wr(7'(i), 32'hA0 + 32'(i));
    commit();
    swap(7'd10);
    chk("b0_under", {31'h0, underrun_p}, 32'h0);
    chk("b0_sil", {31'h0, bsm_silence}, 32'h0);
    for (int i = 0; i < 10; i++) rd_chk("b0_rd", 32'hA0 + 32'(i));
    tick();
    chk("b0_dv_idle", {31'h0, bsm_dvalid}, 32'h0);

    // Write held off by a 5-read burst (reads saturate at word 9)
    lnctrl_we = 1'b1; lnctrl_addr = 7'd0; lnctrl_din = 32'hB0; bsm_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("burst_rdy", {31'h0, lnctrl_rdy}, 32'h0);
      tick();
      chk("burst_dout", bsm_dout, 32'hA9);
    end
    bsm_rd = 1'b0;
    #1 chk("burst_rdy6", {31'h0, lnctrl_rdy}, 32'h1);
    tick();
    lnctrl_we = 1'b0;
    wr(7'd1, 32'hB1);
    wr(7'd2, 32'hB2);
    commit();
    swap(7'd3);
    chk("b1_under", {31'h0, underrun_p}, 32'h0);
    rd_chk("b1_rd0", 32'hB0);
    rd_chk("b1_rd1", 32'hB1);
    rd_chk("b1_rd2", 32'hB2);
    rd_chk("b1_sat", 32'hB2);
    bsm_rd_start = 1'b1; tick(); bsm_rd_start = 1'b0;
    rd_chk("b1_re0", 32'hB0);
    rd_chk("b1_re1", 32'hB1);
    bsm_rd_start = 1'b1;
    rd_chk("b1_start_rd", 32'hB0);
    bsm_rd_start = 1'b0;

    // Underrun: swap with nothing committed
    swap(7'd4);
    chk("ur_pulse", {31'h0, underrun_p}, 32'h1);
    chk("ur_sil", {31'h0, bsm_silence}, 32'h1);
    tick();
    chk("ur_pulse_end", {31'h0, underrun_p}, 32'h0);
    rd_chk("ur_rd", 32'h0);

    // Commit and Tsco in the same cycle
    wr(7'd0, 32'hC0);
    wr(7'd1, 32'hC1);
    lnctrl_commit = 1'b1; tsco_p = 1'b1; pyl_words = 7'd2;
    tick();
    lnctrl_commit = 1'b0; tsco_p = 1'b0;
    chk("cs_under", {31'h0, underrun_p}, 32'h0);
    chk("cs_sil", {31'h0, bsm_silence}, 32'h0);
    rd_chk("cs_rd0", 32'hC0);
    rd_chk("cs_rd1", 32'hC1);

    // Commit on empty bank, then a write to the FULL bank is dropped
    commit();
    wr(7'd0, 32'hDEAD);
    chk("ov_pulse", {31'h0, overflow_p}, 32'h1);
    tick();
    chk("ov_pulse_end", {31'h0, overflow_p}, 32'h0);
    swap(7'd2);
    chk("blank_under", {31'h0, underrun_p}, 32'h0);
    chk("blank_sil", {31'h0, bsm_silence}, 32'h0);
    rd_chk("blank_rd0", 32'h0);

    // sco_en flush after a committed fill
    wr(7'd0, 32'hE0);
    commit();
    sco_en = 1'b0;
    tick();
    chk_idle("flush");
    sco_en = 1'b1;
    swap(7'd1);
    chk("flush_under", {31'h0, underrun_p}, 32'h1);

    // Async reset mid-drain
    wr(7'd0, 32'hF0);
    commit();
    swap(7'd1);
    chk("rst_sil_pre", {31'h0, bsm_silence}, 32'h0);
    rd_chk("rst_rd", 32'hF0);
    bsm_rd = 1'b1;
    #2 rstz = 1'b0;
    #1 chk_idle("async_rst");
    bsm_rd = 1'b0;
    tick();
    rstz = 1'b1;
    tick();
    swap(7'd1);
    chk("rst_under", {31'h0, underrun_p}, 32'h1);
    chk("rst_sil", {31'h0, bsm_silence}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
